// File: rtl/pic_irq_arbiter.sv
// pic_irq_arbiter: rotating-priority resolver with in-service register and INT/INTA handshake
module pic_irq_arbiter #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W = $clog2(NUM_IRQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               special_mask,
    input  logic               rotate_on_eoi,
    input  logic               auto_eoi,
    input  logic               inta_ack,
    input  logic               eoi_valid,
    input  logic               eoi_specific,
    input  logic [ID_W-1:0]    eoi_id,
    input  logic               set_prio_valid,
    input  logic [ID_W-1:0]    set_prio_id,
    output logic               int_out,
    output logic               ack_valid,
    output logic [ID_W-1:0]    ack_id,
    output logic               ack_spurious,
    output logic [NUM_IRQ-1:0] irq_clear,
    output logic [NUM_IRQ-1:0] isr,
    output logic [ID_W-1:0]    lowest_prio
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
    state_t state;
    logic [NUM_IRQ-1:0] cand, eff_isr, clr_mask, set_mask;
    logic [ID_W:0] c_hi, e_hi, i_hi;
    logic [ID_W-1:0] win_id, hi_id, clr_id;
    logic win, fire, cleared;

    // returns {found, rank} of the highest-priority set bit; rank 0 is channel lp+1
    function automatic logic [ID_W:0] find_hi(input logic [NUM_IRQ-1:0] v, input logic [ID_W-1:0] lp);
        logic [ID_W:0] r;
        logic [ID_W-1:0] idx;
        r = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            idx = lp + ID_W'(k + 1);
            if (v[idx]) r = {1'b1, ID_W'(k)};
        end
        return r;
    endfunction

    // arbitration on pre-update state, plus EOI / acknowledge ISR edit masks
    always_comb begin
        cand = irq_req & ~irq_mask & ~isr;
        eff_isr = special_mask ? isr & ~irq_mask : isr;
        c_hi = find_hi(cand, lowest_prio);
        e_hi = find_hi(eff_isr, lowest_prio);
        i_hi = find_hi(isr, lowest_prio);
        win = c_hi[ID_W] && (!e_hi[ID_W] || c_hi[ID_W-1:0] < e_hi[ID_W-1:0]);
        win_id = lowest_prio + c_hi[ID_W-1:0] + ID_W'(1);
        hi_id = lowest_prio + i_hi[ID_W-1:0] + ID_W'(1);
        fire = state == REQ && inta_ack;
        clr_id = eoi_specific ? eoi_id : hi_id;
        clr_mask = eoi_valid ? NUM_IRQ'(1) << clr_id : '0;
        cleared = |(isr & clr_mask);
        set_mask = fire && win && !auto_eoi ? NUM_IRQ'(1) << win_id : '0;
    end

    // handshake FSM with registered int_out
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            int_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (win) begin
                    state <= REQ;
                    int_out <= 1'b1;
                end
                REQ: if (inta_ack) begin
                    state <= HOLD;
                    int_out <= 1'b0;
                end else if (!win) begin
                    state <= IDLE;
                    int_out <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    int_out <= 1'b0;
                end
            endcase
        end
    end

    // acknowledge results, ISR update (clear then set) and priority pointer
    always_ff @(posedge clock) begin
        if (reset) begin
            ack_valid <= 1'b0;
            ack_id <= '0;
            ack_spurious <= 1'b0;
            irq_clear <= '0;
            isr <= '0;
            lowest_prio <= ID_W'(NUM_IRQ - 1);
        end else begin
            ack_valid <= fire;
            irq_clear <= fire && win ? NUM_IRQ'(1) << win_id : '0;
            if (fire) begin
                ack_id <= win ? win_id : ID_W'(NUM_IRQ - 1);
                ack_spurious <= !win;
            end
            isr <= (isr & ~clr_mask) | set_mask;
            lowest_prio <= set_prio_valid ? set_prio_id :
                           rotate_on_eoi && cleared ? clr_id :
                           fire && win && auto_eoi && rotate_on_eoi ? win_id : lowest_prio;
        end
    end
endmodule

// File: tb/tb_pic_irq_arbiter.sv
// tb_pic_irq_arbiter: vector table, directed corner sequences and random run against a reference model
module tb_pic_irq_arbiter;
    localparam int N = 8;
    logic clk = 1'b0;
    logic rst, sm, roe, aeoi, inta, eoi, eois, spv;
    logic [7:0] req, mask;
    logic [2:0] eoiid, spid;
    logic int_out, ack_valid, ack_spurious;
    logic [2:0] ack_id, lowest_prio;
    logic [7:0] irq_clear, isr;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pic_irq_arbiter #(.NUM_IRQ(N), .ID_W(3)) dut (
        .clock(clk), .reset(rst), .irq_req(req), .irq_mask(mask),
        .special_mask(sm), .rotate_on_eoi(roe), .auto_eoi(aeoi), .inta_ack(inta),
        .eoi_valid(eoi), .eoi_specific(eois), .eoi_id(eoiid),
        .set_prio_valid(spv), .set_prio_id(spid),
        .int_out(int_out), .ack_valid(ack_valid), .ack_id(ack_id), .ack_spurious(ack_spurious),
        .irq_clear(irq_clear), .isr(isr), .lowest_prio(lowest_prio)
    );

    // packed view {int_out, ack_valid, ack_id, ack_spurious, irq_clear, isr, lowest_prio};
    // ack_id/ack_spurious only matter while ack_valid is high
    function automatic logic [24:0] pk(input logic io, input logic av, input logic [2:0] id,
                                       input logic sp, input logic [7:0] cl, input logic [7:0] is,
                                       input logic [2:0] lp);
        return {io, av, av ? id : 3'd0, av ? sp : 1'b0, cl, is, lp};
    endfunction

    function automatic logic [24:0] dut_vec();
        return pk(int_out, ack_valid, ack_id, ack_spurious, irq_clear, isr, lowest_prio);
    endfunction

    task automatic chk(input string nm, input logic [24:0] got, input logic [24:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got int=%b av=%b id=%0d sp=%b clr=%h isr=%h lp=%0d, expected int=%b av=%b id=%0d sp=%b clr=%h isr=%h lp=%0d",
                     nm, got[24], got[23], got[22:20], got[19], got[18:11], got[10:3], got[2:0],
                     exp[24], exp[23], exp[22:20], exp[19], exp[18:11], exp[10:3], exp[2:0]);
        end
    endtask

    // reference model: priority by rank arithmetic over channel numbers
    int m_st;
    logic m_int, m_av, m_sp;
    logic [2:0] m_id, m_lp;
    logic [7:0] m_clr, m_isr;

    function automatic int rk(input int ch, input logic [2:0] lp);
        return (ch - int'(lp) - 1 + 2 * N) % N;
    endfunction

    task automatic model_step();
        int best, blk, clrd;
        bit win, fire;
        logic [7:0] nisr;
        logic [2:0] nlp;
        if (rst) begin
            m_st = 0; m_int = 0; m_av = 0; m_id = 0; m_sp = 0; m_clr = 0; m_isr = 0; m_lp = 3'd7;
        end else begin
            best = -1;
            blk = -1;
            for (int c = 0; c < N; c++) begin
                if (req[c] && !mask[c] && !m_isr[c] && (best < 0 || rk(c, m_lp) < rk(best, m_lp))) best = c;
                if (m_isr[c] && !(sm && mask[c]) && (blk < 0 || rk(c, m_lp) < rk(blk, m_lp))) blk = c;
            end
            win = best >= 0 && (blk < 0 || rk(best, m_lp) < rk(blk, m_lp));
            fire = m_st == 1 && inta;
            m_av = fire;
            m_clr = 0;
            if (fire) begin
                m_id = win ? 3'(best) : 3'd7;
                m_sp = !win;
                if (win) m_clr[best] = 1'b1;
            end
            clrd = -1;
            if (eoi) begin
                if (eois) begin
                    if (m_isr[eoiid]) clrd = int'(eoiid);
                end else begin
                    for (int c = 0; c < N; c++)
                        if (m_isr[c] && (clrd < 0 || rk(c, m_lp) < rk(clrd, m_lp))) clrd = c;
                end
            end
            nisr = m_isr;
            if (clrd >= 0) nisr[clrd] = 1'b0;
            if (fire && win && !aeoi) nisr[best] = 1'b1;
            nlp = m_lp;
            if (spv) nlp = spid;
            else if (roe && clrd >= 0) nlp = 3'(clrd);
            else if (fire && win && aeoi && roe) nlp = 3'(best);
            case (m_st)
                0: m_st = win ? 1 : 0;
                1: m_st = inta ? 2 : (win ? 1 : 0);
                default: m_st = 0;
            endcase
            m_int = m_st == 1;
            m_isr = nisr;
            m_lp = nlp;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("model", dut_vec(), pk(m_int, m_av, m_id, m_sp, m_clr, m_isr, m_lp));
    endtask

    task automatic cyc(input logic r, input logic [7:0] q, input logic [7:0] m, input logic s,
                       input logic ro, input logic ae, input logic ia, input logic e, input logic es,
                       input logic [2:0] ei, input logic p, input logic [2:0] pi);
        rst = r; req = q; mask = m; sm = s; roe = ro; aeoi = ae;
        inta = ia; eoi = e; eois = es; eoiid = ei; spv = p; spid = pi;
        step();
    endtask

    typedef struct {
        logic rst;
        logic [7:0] req;
        logic roe, inta, eoi, eois;
        logic [2:0] eoiid;
        logic [24:0] exp;
    } vec_t;
    vec_t tbl[15];

    function automatic vec_t mk(input logic r, input logic [7:0] q, input logic ro, input logic ia,
                                input logic e, input logic es, input logic [2:0] ei, input logic [24:0] x);
        vec_t v;
        v.rst = r; v.req = q; v.roe = ro; v.inta = ia; v.eoi = e; v.eois = es; v.eoiid = ei; v.exp = x;
        return v;
    endfunction

    initial begin
        tbl[0]  = mk(1, 8'h00, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 8'h00, 8'h00, 7));
        tbl[1]  = mk(0, 8'h28, 0, 0, 0, 0, 0, pk(1, 0, 0, 0, 8'h00, 8'h00, 7));
        tbl[2]  = mk(0, 8'h28, 0, 1, 0, 0, 0, pk(0, 1, 3, 0, 8'h08, 8'h08, 7));
        tbl[3]  = mk(0, 8'h20, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 8'h00, 8'h08, 7));
        tbl[4]  = mk(0, 8'h20, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 8'h00, 8'h08, 7));
        tbl[5]  = mk(0, 8'h22, 0, 0, 0, 0, 0, pk(1, 0, 0, 0, 8'h00, 8'h08, 7));
        tbl[6]  = mk(0, 8'h22, 0, 1, 0, 0, 0, pk(0, 1, 1, 0, 8'h02, 8'h0A, 7));
        tbl[7]  = mk(0, 8'h20, 0, 0, 1, 0, 0, pk(0, 0, 0, 0, 8'h00, 8'h08, 7));
        tbl[8]  = mk(0, 8'h20, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 8'h00, 8'h08, 7));
        tbl[9]  = mk(1, 8'h00, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 8'h00, 8'h00, 7));
        tbl[10] = mk(0, 8'h04, 1, 0, 0, 0, 0, pk(1, 0, 0, 0, 8'h00, 8'h00, 7));
        tbl[11] = mk(0, 8'h04, 1, 1, 0, 0, 0, pk(0, 1, 2, 0, 8'h04, 8'h04, 7));
        tbl[12] = mk(0, 8'h00, 1, 0, 1, 1, 2, pk(0, 0, 0, 0, 8'h00, 8'h00, 2));
        tbl[13] = mk(0, 8'h06, 1, 0, 0, 0, 0, pk(1, 0, 0, 0, 8'h00, 8'h00, 2));
        tbl[14] = mk(0, 8'h06, 1, 1, 0, 0, 0, pk(0, 1, 1, 0, 8'h02, 8'h02, 2));
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].rst, tbl[i].req, 8'h00, 0, tbl[i].roe, 0, tbl[i].inta, tbl[i].eoi,
                tbl[i].eois, tbl[i].eoiid, 0, 0);
            chk($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
        end

        // spurious: request vanishes in the acknowledge cycle
        cyc(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 8'h10, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("s4_req", dut_vec(), pk(1, 0, 0, 0, 8'h00, 8'h00, 7));
        cyc(0, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("s4_spurious", dut_vec(), pk(0, 1, 7, 1, 8'h00, 8'h00, 7));

        // special mask unblocks a lower channel behind a masked in-service one
        cyc(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 8'h01, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 8'h01, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("s5_isr0", dut_vec(), pk(0, 1, 0, 0, 8'h01, 8'h01, 7));
        cyc(0, 8'h10, 8'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 8'h10, 8'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("s5_blocked", dut_vec(), pk(0, 0, 0, 0, 8'h00, 8'h01, 7));
        cyc(0, 8'h10, 8'h01, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("s5_smm_int", dut_vec(), pk(1, 0, 0, 0, 8'h00, 8'h01, 7));
        cyc(0, 8'h10, 8'h01, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("s5_smm_ack", dut_vec(), pk(0, 1, 4, 0, 8'h10, 8'h11, 7));

        // EOI + acknowledge + set_prio in one cycle, then reset in REQ with strobes
        cyc(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 8'h04, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 8'h04, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 8'h06, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 8'h06, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("s6_req", dut_vec(), pk(1, 0, 0, 0, 8'h00, 8'h04, 7));
        cyc(0, 8'h06, 8'h00, 0, 1, 0, 1, 1, 0, 0, 1, 5);
        chk("s6_same_cycle", dut_vec(), pk(0, 1, 1, 0, 8'h02, 8'h02, 5));
        cyc(0, 8'h01, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 8'h01, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("s6_req2", dut_vec(), pk(1, 0, 0, 0, 8'h00, 8'h02, 5));
        cyc(1, 8'h01, 8'h00, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        chk("s6_reset", dut_vec(), pk(0, 0, 0, 0, 8'h00, 8'h00, 7));

        // auto-EOI rotation, then specific EOI of the bit being acknowledged
        cyc(0, 8'h08, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 8'h08, 8'h00, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        chk("s7_auto_eoi", dut_vec(), pk(0, 1, 3, 0, 8'h08, 8'h00, 3));
        cyc(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 8'h01, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 8'h01, 8'h00, 0, 1, 0, 1, 1, 1, 0, 0, 0);
        chk("s7_same_bit", dut_vec(), pk(0, 1, 0, 0, 8'h01, 8'h01, 3));

        // random traffic against the model
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 63) == 0, 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255) & $urandom_range(0, 255) & $urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), $urandom_range(0, 9) == 0, 3'($urandom_range(0, 7)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
